ldl_parity_insert: RTL and testbench

Transmit-side parity generator for the byte-stream packet interface used by the parity checker. It forwards packets beat by beat. At end-of-packet it appends a PAR_BYTES-wide parity field directly after the last valid payload byte, so that at the far end the XOR of all PAR_BITS lanes (invalid bytes masked) equals all-ones. It sits in front of the link/FIFO that feeds the receive-side checker.

---
 rtl/ldl_parity_insert_if.sv | 35 +++
 rtl/ldl_parity_insert.sv | 164 ++++++++++++++++
 tb/tb_ldl_parity_insert.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ldl_parity_insert_if.sv
// ldl_parity_insert_if: byte-stream packet bus around the parity inserter.
//   en                 parity insertion enable, sampled on a packet's first beat
//   in_data/in_bnum    input beat, byte 0 in the MSBs; bnum = valid bytes on eop (0 = all)
//   in_valid/in_eop    input beat qualifiers
//   in_ready           input accept (driven by the inserter)
//   out_data/out_bnum  output beat, same encoding; invalid bytes are zero
//   out_valid/out_eop  output beat qualifiers (driven by the inserter)
//   out_ready          downstream accept
// master = upstream/downstream environment view, slave = inserter view.
interface ldl_parity_insert_if #(
  parameter int DATA_WIDTH = 256,
  parameter int BNUM_W     = 5
);
  logic                  en;
  logic [DATA_WIDTH-1:0] in_data;
  logic [BNUM_W-1:0]     in_bnum;
  logic                  in_valid;
  logic                  in_eop;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [BNUM_W-1:0]     out_bnum;
  logic                  out_valid;
  logic                  out_eop;
  logic                  out_ready;

  modport master (
    output en, in_data, in_bnum, in_valid, in_eop, out_ready,
    input  in_ready, out_data, out_bnum, out_valid, out_eop
  );

  modport slave (
    input  en, in_data, in_bnum, in_valid, in_eop, out_ready,
    output in_ready, out_data, out_bnum, out_valid, out_eop
  );
endinterface

// File: rtl/ldl_parity_insert.sv
// ldl_parity_insert: transmit-side parity generator. Forwards packets beat by
// beat through one output register and, when enabled, appends a PAR_BYTES
// parity field right after the last valid payload byte so that the XOR of all
// PAR_BITS lanes of the packet (invalid bytes masked) is all-ones.
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    ldl_parity_insert_if.slave (input stream, output stream, en)
module ldl_parity_insert #(
  parameter int PAR_BYTES  = 4,
  parameter int DATA_WIDTH = 256,
  parameter int BYTE_NUM   = DATA_WIDTH / 8
) (
  input logic                clk,
  input logic                rst_n,
  ldl_parity_insert_if.slave bus
);
  localparam int PAR_BITS = 8 * PAR_BYTES;
  localparam int BNUM_W   = $clog2(BYTE_NUM);
  localparam int LANES    = BYTE_NUM / PAR_BYTES;
  localparam int TN_W     = BNUM_W + 1;

  typedef enum logic [1:0] {
    SOP  = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  pkt_en_q, pkt_en_d;
  logic [PAR_BITS-1:0]   acc_q, acc_d;
  logic [PAR_BITS-1:0]   fld_q, fld_d;
  logic [TN_W-1:0]       tail_n_q, tail_n_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [BNUM_W-1:0]     out_bnum_q, out_bnum_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_eop_q, out_eop_d;

  logic                  load, in_ready, accept, eff_en;
  logic [31:0]           pos, lim, end_pos;
  logic [DATA_WIDTH-1:0] masked, ins_data, tail_data;
  logic [PAR_BITS-1:0]   lane_x, acc_new, par;

  // Datapath: masking, lane folding, parity placement.
  always_comb begin
    load     = !out_valid_q || bus.out_ready;
    in_ready = load && (state_q != TAIL);
    accept   = bus.in_valid && in_ready;

    pos     = (bus.in_bnum == '0) ? 32'(BYTE_NUM) : 32'(bus.in_bnum);
    lim     = bus.in_eop ? pos : 32'(BYTE_NUM);
    end_pos = pos + 32'(PAR_BYTES);

    masked = '0;
    for (int unsigned b = 0; b < BYTE_NUM; b++) begin
      if (b < lim) masked[DATA_WIDTH-1-8*b -: 8] = bus.in_data[DATA_WIDTH-1-8*b -: 8];
    end

    lane_x = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_x = lane_x ^ masked[DATA_WIDTH-1-PAR_BITS*l -: PAR_BITS];
    end

    // First beat of a packet loads the accumulator instead of folding into it.
    acc_new = ((state_q == SOP) ? '0 : acc_q) ^ lane_x;
    par     = ~acc_new;
    eff_en  = (state_q == SOP) ? bus.en : pkt_en_q;

    // Beat sizes are a multiple of PAR_BYTES, so the lane byte for stream
    // offset pos+k reduces to the in-beat byte index mod PAR_BYTES.
    ins_data = masked;
    if (bus.in_eop && eff_en) begin
      for (int unsigned b = 0; b < BYTE_NUM; b++) begin
        if (b >= pos && b < end_pos)
          ins_data[DATA_WIDTH-1-8*b -: 8] = par[PAR_BITS-1-8*(b % PAR_BYTES) -: 8];
      end
    end

    tail_data = '0;
    for (int unsigned t = 0; t < BYTE_NUM; t++) begin
      if (t < 32'(tail_n_q))
        tail_data[DATA_WIDTH-1-8*t -: 8] = fld_q[PAR_BITS-1-8*(t % PAR_BYTES) -: 8];
    end
  end

  // Next state / output register load.
  always_comb begin
    state_d     = state_q;
    pkt_en_d    = pkt_en_q;
    acc_d       = acc_q;
    fld_d       = fld_q;
    tail_n_d    = tail_n_q;
    out_data_d  = out_data_q;
    out_bnum_d  = out_bnum_q;
    out_valid_d = out_valid_q;
    out_eop_d   = out_eop_q;

    if (load) begin
      out_valid_d = 1'b0;
      out_eop_d   = 1'b0;
      out_bnum_d  = '0;
      out_data_d  = '0;
      if (state_q == TAIL) begin
        out_valid_d = 1'b1;
        out_eop_d   = 1'b1;
        out_bnum_d  = BNUM_W'(tail_n_q);
        out_data_d  = tail_data;
        state_d     = SOP;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = ins_data;
        acc_d       = acc_new;
        if (state_q == SOP) pkt_en_d = bus.en;
        if (!bus.in_eop) begin
          state_d = BODY;
        end else if (!eff_en) begin
          out_eop_d  = 1'b1;
          out_bnum_d = bus.in_bnum;
          state_d    = SOP;
        end else if (end_pos < 32'(BYTE_NUM)) begin
          out_eop_d  = 1'b1;
          out_bnum_d = BNUM_W'(end_pos);
          state_d    = SOP;
        end else if (end_pos == 32'(BYTE_NUM)) begin
          out_eop_d  = 1'b1;
          state_d    = SOP;
        end else begin
          fld_d    = par;
          tail_n_d = TN_W'(end_pos - 32'(BYTE_NUM));
          state_d  = TAIL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SOP;
      pkt_en_q    <= 1'b0;
      acc_q       <= '0;
      fld_q       <= '0;
      tail_n_q    <= '0;
      out_data_q  <= '0;
      out_bnum_q  <= '0;
      out_valid_q <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_en_q    <= pkt_en_d;
      acc_q       <= acc_d;
      fld_q       <= fld_d;
      tail_n_q    <= tail_n_d;
      out_data_q  <= out_data_d;
      out_bnum_q  <= out_bnum_d;
      out_valid_q <= out_valid_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_bnum  = out_bnum_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_eop   = out_eop_q;
endmodule

// File: tb/tb_ldl_parity_insert.sv
// tb_ldl_parity_insert: directed bench for ldl_parity_insert (PAR_BYTES=4,
// DATA_WIDTH=64). Expected beats come from a byte-stream model and are
// checked by a monitor as the DUT emits them.
module tb_ldl_parity_insert;
  localparam int DW = 64;
  localparam int PB = 4;
  localparam int BN = 8;
  localparam int BW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ldl_parity_insert_if #(.DATA_WIDTH(DW), .BNUM_W(BW)) bus ();

  ldl_parity_insert #(.PAR_BYTES(PB), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [BW-1:0] b;
    logic          e;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pkt[$];
  int         checks = 0;
  int         errors = 0;
  int         stall_at = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pkt(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
  endtask

  // Stream model: lane byte i of P is the XOR of all stream bytes at offset
  // i mod PB; the field byte at stream offset L+k is ~P[(L+k) mod PB].
  task automatic build_expected(input logic en);
    logic [7:0] s[$];
    logic [7:0] p[PB];
    int         len;
    s   = pkt;
    len = s.size();
    if (en) begin
      for (int i = 0; i < PB; i++) p[i] = 8'h00;
      for (int i = 0; i < len; i++) p[i % PB] ^= s[i];
      for (int k = 0; k < PB; k++) s.push_back(~p[(len + k) % PB]);
    end
    for (int i = 0; i < s.size(); i += BN) begin
      beat_t bt;
      bt.d = '0;
      for (int j = 0; j < BN && i + j < s.size(); j++) bt.d[DW-1-8*j -: 8] = s[i+j];
      bt.e = (i + BN >= s.size());
      bt.b = bt.e ? BW'((s.size() - i) % BN) : '0;
      exp_q.push_back(bt);
    end
  endtask

  task automatic wait_accept();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1'b1);
  endtask

  task automatic send_pkt(input logic en);
    int            len, nb, nv;
    logic [DW-1:0] d, sd;
    logic [BW-1:0] sb;
    logic          se;
    len = pkt.size();
    nb  = (len + BN - 1) / BN;
    for (int i = 0; i < nb; i++) begin
      nv = (len - i * BN < BN) ? len - i * BN : BN;
      d  = '0;
      for (int j = 0; j < BN; j++)
        d[DW-1-8*j -: 8] = (j < nv) ? pkt[i*BN+j] : (en ? 8'h5A : 8'h00);
      bus.in_data  = d;
      bus.in_eop   = (i == nb - 1);
      bus.in_bnum  = (i == nb - 1) ? BW'(nv % BN) : BW'($urandom);
      bus.en       = (i == 0) ? en : ~en;
      bus.in_valid = 1'b1;
      if (i == stall_at) begin
        bus.out_ready = 1'b0;
        #1;
        sd = bus.out_data;
        sb = bus.out_bnum;
        se = bus.out_eop;
        for (int c = 0; c < 3; c++) begin
          chk("stall_in_ready", bus.in_ready, 1'b0);
          step();
          chk("stall_valid", bus.out_valid, 1'b1);
          chk("stall_data", bus.out_data, sd);
          chk("stall_bnum", bus.out_bnum, sb);
          chk("stall_eop", bus.out_eop, se);
        end
        bus.out_ready = 1'b1;
      end
      wait_accept();
    end
    bus.in_valid = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) step();
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: a beat transfers at the posedge following this sample.
  beat_t e;
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL spurious_beat observed=%h expected=no beat", bus.out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_bnum", bus.out_bnum, e.b);
        chk("out_eop", bus.out_eop, e.e);
      end
    end
  end

  initial begin
    bus.en        = 1'b0;
    bus.in_data   = '0;
    bus.in_bnum   = '0;
    bus.in_valid  = 1'b0;
    bus.in_eop    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_eop", bus.out_eop, 1'b0);
    chk("rst_out_bnum", bus.out_bnum, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Field fills the eop beat exactly.
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_expected(1'b1);
    send_pkt(1'b1);
    wait_drain();

    // Full eop beat: whole field in the tail beat, input blocked meanwhile.
    pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    build_expected(1'b1);
    send_pkt(1'b1);
    chk("tail_in_ready", bus.in_ready, 1'b0);
    step();
    chk("post_tail_in_ready", bus.in_ready, 1'b1);
    wait_drain();

    // Field split across eop beat and tail.
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    build_expected(1'b1);
    send_pkt(1'b1);
    wait_drain();

    // 3-beat packet with a downstream stall, then a back-to-back packet.
    rand_pkt(20);
    build_expected(1'b1);
    stall_at = 1;
    send_pkt(1'b1);
    stall_at = -1;
    rand_pkt(13);
    build_expected(1'b1);
    send_pkt(1'b1);
    wait_drain();

    // Pass-through with insertion disabled.
    rand_pkt(13);
    build_expected(1'b0);
    send_pkt(1'b0);
    wait_drain();

    // Field fits with bytes to spare; single-byte packet.
    rand_pkt(10);
    build_expected(1'b1);
    send_pkt(1'b1);
    rand_pkt(1);
    build_expected(1'b1);
    send_pkt(1'b1);
    wait_drain();

    // Reset while a tail is pending.
    bus.out_ready = 1'b0;
    rand_pkt(8);
    send_pkt(1'b1);
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 1'b0);
    chk("async_rst_eop", bus.out_eop, 1'b0);
    chk("async_rst_data", bus.out_data, 0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) step();
    rand_pkt(7);
    build_expected(1'b1);
    send_pkt(1'b1);
    wait_drain();

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
